// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, one synchronous write port,
// optional write-to-read bypass, hardwired-zero x0 and a pending-write scoreboard.
module regfile_sb #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG),
  localparam int CW     = $clog2(NREG + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_addr,
  input  logic                flush,
  output logic [CW-1:0]       busy_cnt,
  output logic                err
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic            wr_en;

  assign wr_en = we && (wa != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // Issue is applied after the writeback clear so a new producer wins on the same address.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_en) busy_nxt[wa] = 1'b0;
      if (issue_valid && (issue_addr != '0)) busy_nxt[issue_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
      err      <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      if (wr_en && !busy[wa] && !flush) err <= 1'b1;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic          fwd;
    assign a   = rd_addr[p*AW +: AW];
    assign fwd = (BYPASS != 0) && we && (wa == a);
    assign rd_data[p*XLEN +: XLEN] = (a == '0) ? '0 : (fwd ? wd : regs[a]);
    assign rd_busy[p] = (a != '0) && busy[a] && !fwd;
  end

endmodule
